flappy_game_ctrl: RTL

FLAPPY_GAME_CTRL -- requirements
Module: flappy_game_ctrl

---
 rtl/flappy_game_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: game FSM, bird physics, three scrolling pipes, scoring and collision check
module flappy_game_ctrl #(
  parameter int BIRD_X     = 100,
  parameter int PIPE_SPEED = 2,
  parameter int GRAVITY    = 1,
  parameter int FLAP_VEL   = 8,
  parameter int MAX_FALL   = 10,
  parameter int GAP        = 80,
  parameter int PIPE_W     = 40,
  parameter int BIRD_SZ    = 20,
  parameter int Y_FLOOR    = 460
) (
  input  logic       clk_div,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       btn_flap,
  input  logic       start,
  output logic [9:0] bird_x,
  output logic [9:0] bird_y,
  output logic [9:0] pipe1_x,
  output logic [9:0] pipe2_x,
  output logic [9:0] pipe3_x,
  output logic [9:0] pipe1y_up,
  output logic [9:0] pipe2y_up,
  output logic [9:0] pipe3y_up,
  output logic [7:0] score,
  output logic       game_over,
  output logic       playing
);
  typedef enum logic [1:0] {IDLE, PLAY, CHECK, DEAD} state_t;
  localparam logic signed [5:0]  GR = GRAVITY[5:0];
  localparam logic signed [5:0]  FV = FLAP_VEL[5:0];
  localparam logic signed [5:0]  MF = MAX_FALL[5:0];
  localparam logic signed [10:0] YF = Y_FLOOR[10:0];
  localparam logic [9:0] PX0 [3] = '{10'd400, 10'd613, 10'd826};
  localparam logic [9:0] PU0 [3] = '{10'd120, 10'd200, 10'd160};
  state_t state, state_n;
  logic btn_q, flap_pend, pend_n, floor_hit, floor_n, floor_u, fe, hit;
  logic signed [5:0] vel, vel_n, vel_g, vel_u;
  logic signed [10:0] ys;
  logic [9:0] y_n, y_u;
  logic [9:0] px [3];
  logic [9:0] px_n [3];
  logic [9:0] px_u [3];
  logic [9:0] pu [3];
  logic [9:0] pu_n [3];
  logic [9:0] pu_u [3];
  logic [7:0] score_n, score_u, lfsr;
  logic [8:0] ssum;
  logic [1:0] passes;
  assign fe = btn_flap & ~btn_q;
  assign bird_x = BIRD_X[9:0];
  assign {pipe1_x, pipe2_x, pipe3_x} = {px[0], px[1], px[2]};
  assign {pipe1y_up, pipe2y_up, pipe3y_up} = {pu[0], pu[1], pu[2]};
  // a flap edge landing on the frame tick is folded into that frame
  always_comb begin
    vel_g = vel + GR;
    vel_u = (flap_pend | fe) ? -FV : (vel_g > MF ? MF : vel_g);
    ys = $signed({1'b0, bird_y} + {{5{vel_u[5]}}, vel_u});
    floor_u = ys >= YF;
    y_u = ys[10] ? '0 : floor_u ? Y_FLOOR[9:0] : ys[9:0];
    passes = '0;
    hit = floor_hit;
    for (int i = 0; i < 3; i++) begin
      px_u[i] = px[i] < PIPE_SPEED[9:0] ? px[i] + 10'(640 - PIPE_SPEED) : px[i] - PIPE_SPEED[9:0];
      pu_u[i] = px[i] < PIPE_SPEED[9:0] ? 10'd40 + {2'b0, lfsr} : pu[i];
      passes = passes + 2'({1'b0, px[i]} + PIPE_W[10:0] > BIRD_X[10:0] &&
                           {1'b0, px_u[i]} + PIPE_W[10:0] <= BIRD_X[10:0]);
      hit = hit | ({1'b0, px[i]} < 11'(BIRD_X + BIRD_SZ) && {1'b0, px[i]} + PIPE_W[10:0] > BIRD_X[10:0] &&
                   ({1'b0, bird_y} < {1'b0, pu[i]} || {1'b0, bird_y} + BIRD_SZ[10:0] > {1'b0, pu[i]} + GAP[10:0]));
    end
    ssum = {1'b0, score} + {7'b0, passes};
    score_u = ssum[8] ? 8'hFF : ssum[7:0];
  end
  always_comb begin
    state_n = state;
    pend_n = flap_pend;
    vel_n = vel;
    y_n = bird_y;
    floor_n = floor_hit;
    px_n = px;
    pu_n = pu;
    score_n = score;
    if (start) begin
      state_n = IDLE;
      pend_n = 1'b0;
      vel_n = '0;
      y_n = 10'd220;
      floor_n = 1'b0;
      px_n = PX0;
      pu_n = PU0;
      score_n = state == DEAD ? score : '0;
    end else
      case (state)
        IDLE: if (fe) begin
          state_n = PLAY;
          pend_n = 1'b1;
          score_n = '0;
        end
        PLAY: begin
          pend_n = flap_pend | fe;
          if (frame_tick) begin
            state_n = CHECK;
            pend_n = 1'b0;
            vel_n = vel_u;
            y_n = y_u;
            floor_n = floor_u;
            px_n = px_u;
            pu_n = pu_u;
            score_n = score_u;
          end
        end
        CHECK: begin
          pend_n = flap_pend | fe;
          state_n = hit ? DEAD : PLAY;
        end
        default: pend_n = 1'b0;
      endcase
  end
  always_ff @(posedge clk_div or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      btn_q <= 1'b0;
      flap_pend <= 1'b0;
      vel <= '0;
      bird_y <= 10'd220;
      floor_hit <= 1'b0;
      px <= PX0;
      pu <= PU0;
      score <= '0;
      lfsr <= 8'hA5;
      game_over <= 1'b0;
      playing <= 1'b0;
    end else begin
      state <= state_n;
      btn_q <= btn_flap;
      flap_pend <= pend_n;
      vel <= vel_n;
      bird_y <= y_n;
      floor_hit <= floor_n;
      px <= px_n;
      pu <= pu_n;
      score <= score_n;
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      game_over <= state_n == DEAD;
      playing <= state_n == PLAY || state_n == CHECK;
    end
endmodule
